conv1d_job_sequencer: RTL
=========================

# conv1d_job_sequencer

Sequences the conv1d CFU datapath for one output element per job. Loads the layer-static quantisation and shape parameters once and writes the per-channel parameters for each job. It then starts the accumulation, polls for completion, reads the quantised result and hands it downstream over a valid/ready port. It sits between the CPU-facing job queue and the conv1d command port (cmd/inp0/inp1/ret); it does not touch the input or filter buffers.

## Interface
- `TIMEOUT_CYCLES`, 4096: poll watchdog limit; used only with `CONV1D_SEQ_TIMEOUT_EN`.
- `INT32_SIZE`, 32: data width.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `cfg_valid` / `cfg_ready` in/out 1: layer-config handshake.
- `cfg_input_offset`, `cfg_input_depth`, `cfg_act_min`, `cfg_act_max`, `cfg_output_offset` input 32 each: layer-static values.
- `job_valid` / `job_ready` in/out 1: job handshake.
- `job_start_x`, `job_bias`, `job_multiplier`, `job_shift` input 32 each: per-output parameters.
- `res_valid` / `res_ready` out/in 1: result handshake.
- `res_data` output 32: quantised result.
- `res_timeout` output 1: result produced by watchdog abort.
- `cfu_en` output 1: conv1d enable.
- `cfu_cmd` output 7: conv1d command.
- `cfu_inp0` / `cfu_inp1` output 32: conv1d operands.
- `cfu_ret` input 32: conv1d registered return.
- `busy` output 1: state ≠ IDLE.
- `cfg_loaded` output 1: config written since reset.

## Operation
- States: IDLE, CFG, PARAM, START, POLL, READ, OUT.
- IDLE:
  - `cfg_ready` = 1.
  - `job_ready` = `cfg_loaded`.
  - `cfg_valid` has priority over `job_valid` when both are asserted.
- CFG: issues one command per cycle in this order: cmd 3 (input_offset), 5 (input_depth), 15, 16, 17. Values come from registers captured at the handshake. It then sets `cfg_loaded` and returns to IDLE.
- PARAM: issues one command per cycle in this order: cmd 8 (start_x), 12, 13, 14. Values come from registers captured at the job handshake.
- START: issues cmd 6 for one cycle, then moves to POLL.
- POLL:
  - Issues cmd 9 every cycle.
  - A `sample_ok` flag is set in any cycle where the previous cycle's `cfu_cmd` was 9. `cfu_ret` is sampled only when `sample_ok` is set, because stale `ret` after cmd 6 must be ignored.
  - A sampled `ret[0]` = 1 moves the FSM to READ.
- READ: issues cmd 7. On the next cycle the FSM captures `cfu_ret` into `res_data` and goes to OUT.
- OUT:
  - `res_valid` = 1, and `cfu_cmd` is idle.
  - `res_valid` is held until `res_ready` is sampled high, then the FSM returns to IDLE.
  - `res_data` is stable while `res_valid` is high.
- Idle command:
  - `cfu_cmd` = 7'd127 and `cfu_inp0`/`cfu_inp1` = 0 in IDLE, OUT and any non-issuing cycle.
  - cmd 127 is the conv1d no-op/default.
- `cfu_en` = 1 whenever `rst` = 0.
- `cfu_inp0` is always 0, since no address-type commands are issued.

## Timing
- Reset values:
  - FSM state, `cfg_loaded`, `res_valid`, `res_timeout`, `busy`, `cfu_en` = 0.
  - `res_data` = 0.
  - `cfu_cmd` = 127; `cfu_inp0` and `cfu_inp1` = 0.
  - `cfg_ready` and `job_ready` = 0 during reset.
- Job latency: accept at cycle t.
  - cmd 8 is issued at t+1, cmd 14 at t+4, cmd 6 at t+5.
  - The first cmd 9 is issued at t+6 and the first valid sample is taken at t+7.
  - cmd 7 is issued one cycle after the sample reads 1; `res_valid` rises 2 cycles after cmd 7.
- Config: 5 command cycles; `cfg_ready` returns at accept+6.
- Job vs config: a job is never accepted while a config write is in progress. A new config is accepted only in IDLE and is applied to subsequent jobs.
- Reset mid-job:
  - The FSM returns to IDLE and `cfg_loaded` clears.
  - The conv1d may keep computing. The next job's cmd 6 restarts it, so no flush is needed.
- Back-to-back: `job_ready` is low from accept until the OUT handshake completes. At most one job is in flight.

## Configuration
- `CONV1D_SEQ_TIMEOUT_EN` defined:
  - A 32-bit counter clears on POLL entry and increments per POLL cycle.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to OUT with `res_data` = 0 and `res_timeout` = 1.
  - `res_timeout` clears when the FSM leaves OUT.
- Undefined: no counter; POLL waits indefinitely; `res_timeout` is tied to 0.

## Structure
- Shared package `conv1d_pkg` holds:
  - the conv1d command constants: RESET 0, WR_INPUT 1, WR_FILTER 2, INPUT_OFFSET 3, INPUT_DEPTH 5, START 6, GET_ACC 7, START_X 8, POLL 9, BIAS 12, MULT 13, SHIFT 14, ACT_MIN 15, ACT_MAX 16, OUT_OFFSET 17, NOP 127;
  - the state enum `seq_state_t`.
- Single module; the watchdog is inline. No sub-module is needed.

## Test plan
- Config with offset=128, depth=16, min=-128, max=127, out_off=-5 → `cfu_cmd` sequence 3, 5, 15, 16, 17 on consecutive cycles with matching `cfu_inp1`; `cfg_loaded` = 1 afterwards.
- Job before any config → `job_ready` = 0 and no commands issued.
- Job with start_x=2 against a conv1d model finishing 20 cycles after cmd 6 and returning 0x0000_0031 → `res_data` = 0x31; a stale `ret` = 1 present at the first POLL cycle is ignored.
- `res_ready` held low for 10 cycles → `res_valid` and `res_data` stay stable and `job_ready` stays 0.
- Assert `rst` during POLL → next cycle is IDLE, `cfu_cmd` = 127, `cfg_loaded` = 0.
- With `CONV1D_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, model never finishes → `res_valid` with `res_data` = 0 and `res_timeout` = 1 after 16 POLL cycles.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared conv1d definitions: command opcodes understood by the conv1d CFU
// and the job sequencer state encoding.
package conv1d_pkg;

    localparam logic [6:0] CMD_RESET        = 7'd0;
    localparam logic [6:0] CMD_WR_INPUT     = 7'd1;
    localparam logic [6:0] CMD_WR_FILTER    = 7'd2;
    localparam logic [6:0] CMD_INPUT_OFFSET = 7'd3;
    localparam logic [6:0] CMD_INPUT_DEPTH  = 7'd5;
    localparam logic [6:0] CMD_START        = 7'd6;
    localparam logic [6:0] CMD_GET_ACC      = 7'd7;
    localparam logic [6:0] CMD_START_X      = 7'd8;
    localparam logic [6:0] CMD_POLL         = 7'd9;
    localparam logic [6:0] CMD_BIAS         = 7'd12;
    localparam logic [6:0] CMD_MULT         = 7'd13;
    localparam logic [6:0] CMD_SHIFT        = 7'd14;
    localparam logic [6:0] CMD_ACT_MIN      = 7'd15;
    localparam logic [6:0] CMD_ACT_MAX      = 7'd16;
    localparam logic [6:0] CMD_OUT_OFFSET   = 7'd17;
    localparam logic [6:0] CMD_NOP          = 7'd127;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        PARAM,
        START,
        POLL,
        READ,
        OUT
    } seq_state_t;

endpackage

// File: rtl/conv1d_job_sequencer.sv
// Drives the conv1d command port for one output element per job.
// Optional poll watchdog enabled by defining CONV1D_SEQ_TIMEOUT_EN.
module conv1d_job_sequencer
    import conv1d_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int          INT32_SIZE     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [INT32_SIZE-1:0] cfg_input_offset,
    input  logic [INT32_SIZE-1:0] cfg_input_depth,
    input  logic [INT32_SIZE-1:0] cfg_act_min,
    input  logic [INT32_SIZE-1:0] cfg_act_max,
    input  logic [INT32_SIZE-1:0] cfg_output_offset,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [INT32_SIZE-1:0] job_start_x,
    input  logic [INT32_SIZE-1:0] job_bias,
    input  logic [INT32_SIZE-1:0] job_multiplier,
    input  logic [INT32_SIZE-1:0] job_shift,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [INT32_SIZE-1:0] res_data,
    output logic                  res_timeout,
    output logic                  cfu_en,
    output logic [6:0]            cfu_cmd,
    output logic [INT32_SIZE-1:0] cfu_inp0,
    output logic [INT32_SIZE-1:0] cfu_inp1,
    input  logic [INT32_SIZE-1:0] cfu_ret,
    output logic                  busy,
    output logic                  cfg_loaded
);

    seq_state_t            state_q;
    logic [2:0]            step_q;
    logic [6:0]            cmd_q;
    logic [INT32_SIZE-1:0] inp1_q;
    logic                  sample_ok_q;
    logic                  cfg_loaded_q;
    logic                  res_valid_q;
    logic [INT32_SIZE-1:0] res_data_q;
    logic [INT32_SIZE-1:0] depth_q, act_min_q, act_max_q, out_off_q;
    logic [INT32_SIZE-1:0] bias_q, mult_q, shift_q;

`ifdef CONV1D_SEQ_TIMEOUT_EN
    logic [31:0] wd_q;
    logic [31:0] wd_d;
    logic        res_timeout_q;

    assign wd_d        = wd_q + 32'd1;
    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    assign cfg_ready  = (state_q == IDLE) && !rst;
    assign job_ready  = (state_q == IDLE) && cfg_loaded_q && !rst;
    assign busy       = (state_q != IDLE);
    assign cfg_loaded = cfg_loaded_q;
    assign cfu_en     = !rst;
    assign cfu_cmd    = cmd_q;
    assign cfu_inp0   = '0;
    assign cfu_inp1   = inp1_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

    // Command/operand registers are loaded with the value for the following
    // cycle, so each state's command appears in the cycle the state is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            step_q       <= '0;
            cmd_q        <= CMD_NOP;
            inp1_q       <= '0;
            sample_ok_q  <= 1'b0;
            cfg_loaded_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            depth_q      <= '0;
            act_min_q    <= '0;
            act_max_q    <= '0;
            out_off_q    <= '0;
            bias_q       <= '0;
            mult_q       <= '0;
            shift_q      <= '0;
`ifdef CONV1D_SEQ_TIMEOUT_EN
            wd_q          <= '0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            cmd_q       <= CMD_NOP;
            inp1_q      <= '0;
            // ret is registered by the conv1d, so it only reflects a poll
            // when the previous cycle actually issued one.
            sample_ok_q <= (cmd_q == CMD_POLL);
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        depth_q   <= cfg_input_depth;
                        act_min_q <= cfg_act_min;
                        act_max_q <= cfg_act_max;
                        out_off_q <= cfg_output_offset;
                        cmd_q     <= CMD_INPUT_OFFSET;
                        inp1_q    <= cfg_input_offset;
                        step_q    <= '0;
                        state_q   <= CFG;
                    end else if (job_valid && cfg_loaded_q) begin
                        bias_q  <= job_bias;
                        mult_q  <= job_multiplier;
                        shift_q <= job_shift;
                        cmd_q   <= CMD_START_X;
                        inp1_q  <= job_start_x;
                        step_q  <= '0;
                        state_q <= PARAM;
                    end
                end
                CFG: begin
                    step_q <= step_q + 3'd1;
                    case (step_q)
                        3'd0: begin cmd_q <= CMD_INPUT_DEPTH; inp1_q <= depth_q;   end
                        3'd1: begin cmd_q <= CMD_ACT_MIN;     inp1_q <= act_min_q; end
                        3'd2: begin cmd_q <= CMD_ACT_MAX;     inp1_q <= act_max_q; end
                        3'd3: begin cmd_q <= CMD_OUT_OFFSET;  inp1_q <= out_off_q; end
                        default: begin
                            cfg_loaded_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    endcase
                end
                PARAM: begin
                    step_q <= step_q + 3'd1;
                    case (step_q)
                        3'd0: begin cmd_q <= CMD_BIAS;  inp1_q <= bias_q;  end
                        3'd1: begin cmd_q <= CMD_MULT;  inp1_q <= mult_q;  end
                        3'd2: begin cmd_q <= CMD_SHIFT; inp1_q <= shift_q; end
                        default: begin
                            cmd_q   <= CMD_START;
                            state_q <= START;
                        end
                    endcase
                end
                START: begin
                    cmd_q   <= CMD_POLL;
                    state_q <= POLL;
`ifdef CONV1D_SEQ_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                POLL: begin
`ifdef CONV1D_SEQ_TIMEOUT_EN
                    wd_q <= wd_d;
`endif
                    if (sample_ok_q && cfu_ret[0]) begin
                        cmd_q   <= CMD_GET_ACC;
                        step_q  <= '0;
                        state_q <= READ;
                    end
`ifdef CONV1D_SEQ_TIMEOUT_EN
                    else if (wd_d == TIMEOUT_CYCLES) begin
                        res_data_q    <= '0;
                        res_valid_q   <= 1'b1;
                        res_timeout_q <= 1'b1;
                        state_q       <= OUT;
                    end
`endif
                    else begin
                        cmd_q <= CMD_POLL;
                    end
                end
                READ: begin
                    // Result of GET_ACC arrives one cycle after the command.
                    if (step_q == 3'd0) begin
                        step_q <= 3'd1;
                    end else begin
                        res_data_q  <= cfu_ret;
                        res_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
`ifdef CONV1D_SEQ_TIMEOUT_EN
                        res_timeout_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
